// File: rtl/hbridge_pwm_ctrl.sv
// Multi-channel H-bridge PWM controller; every direction reversal passes through a timed brake.
// Define HBRIDGE_RAMP_EN to slew the applied duty by RAMP_STEP per PWM period.
`timescale 1ns/1ps
module hbridge_pwm_ctrl #(
  parameter int NUM_CH    = 2,
  parameter int PWM_BITS  = 8,
  parameter int PRESCALE  = 4,
  parameter int DEADTIME  = 16,
  parameter int RAMP_STEP = 1,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [CW-1:0]              cmd_ch,
  input  logic signed [PWM_BITS:0]   cmd_speed,
  output logic [NUM_CH-1:0]          pwm,
  output logic [NUM_CH-1:0]          ina,
  output logic [NUM_CH-1:0]          inb,
  output logic [NUM_CH-1:0]          busy
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DT_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
`ifdef HBRIDGE_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif
  // Without ramping the step spans the whole duty range, so duty jumps straight to target.
  localparam int STEP = RAMP_ON ? RAMP_STEP : (1 << PWM_BITS);
  localparam logic [PS_W-1:0]         PS_LAST   = PS_W'(PRESCALE - 1);
  localparam logic [DT_W-1:0]         DT_LAST   = DT_W'(DEADTIME - 1);
  localparam logic [DT_W-1:0]         DT_ZERO   = {DT_W{1'b0}};
  localparam logic [PWM_BITS-1:0]     DUTY_ZERO = {PWM_BITS{1'b0}};
  localparam logic signed [PWM_BITS:0] SPD_MIN  = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic signed [PWM_BITS:0] SPD_ONE  = {{PWM_BITS{1'b0}}, 1'b1};
  localparam logic signed [PWM_BITS:0] SPD_ZERO = {(PWM_BITS+1){1'b0}};

  typedef enum logic [1:0] {ST_STOP = 2'd0, ST_DRIVE = 2'd1, ST_BRAKE = 2'd2} state_e;

  logic [PS_W-1:0]           presc_q, presc_d;
  logic [PWM_BITS-1:0]       cnt_q, cnt_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic signed [PWM_BITS:0]  tgt_q [NUM_CH];
  logic signed [PWM_BITS:0]  tgt_d [NUM_CH];
  state_e                    state_q [NUM_CH];
  state_e                    state_d [NUM_CH];
  logic                      dir_q [NUM_CH];
  logic                      dir_d [NUM_CH];
  logic [PWM_BITS-1:0]       duty_q [NUM_CH];
  logic [PWM_BITS-1:0]       duty_d [NUM_CH];
  logic [DT_W-1:0]           brk_q [NUM_CH];
  logic [DT_W-1:0]           brk_d [NUM_CH];
  logic [NUM_CH-1:0]         pwm_q, pwm_d, ina_q, ina_d, inb_q, inb_d, busy_q, busy_d;

  logic                      tick_s, bnd_s, accept_s;
  logic signed [PWM_BITS:0]  cmd_sat_s;
  logic                      sgn_s [NUM_CH];
  logic                      nz_s [NUM_CH];
  logic [PWM_BITS-1:0]       mag_s [NUM_CH];

  function automatic logic [PWM_BITS-1:0] ramp_to(input logic [PWM_BITS-1:0] cur,
                                                  input logic [PWM_BITS-1:0] goal);
    int c;
    int g;
    int r;
    c = int'(cur);
    g = int'(goal);
    if (g > c + STEP) r = c + STEP;
    else if (c > g + STEP) r = c - STEP;
    else r = g;
    return PWM_BITS'(r);
  endfunction

  always_comb begin
    tick_s = (presc_q == PS_LAST);
    bnd_s  = tick_s && (cnt_q == {PWM_BITS{1'b1}});
    if (tick_s) begin
      presc_d = {PS_W{1'b0}};
      cnt_d   = cnt_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
      cnt_d   = cnt_q;
    end
    accept_s    = cmd_valid && cmd_ready_q;
    // The most negative code has no positive twin; clamp it one step in.
    cmd_sat_s   = (cmd_speed == SPD_MIN) ? (cmd_speed + SPD_ONE) : cmd_speed;
    cmd_ready_d = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sgn_s[i] = tgt_q[i][PWM_BITS];
      nz_s[i]  = (tgt_q[i] != SPD_ZERO);
      mag_s[i] = sgn_s[i] ? PWM_BITS'(-tgt_q[i]) : PWM_BITS'(tgt_q[i]);
      if (accept_s && (int'(cmd_ch) == i)) tgt_d[i] = cmd_sat_s;
      else tgt_d[i] = tgt_q[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      dir_d[i]   = dir_q[i];
      duty_d[i]  = duty_q[i];
      brk_d[i]   = brk_q[i];
      if (!enable) begin
        state_d[i] = ST_BRAKE;
        brk_d[i]   = DT_ZERO;
      end else if (bnd_s) begin
        case (state_q[i])
          ST_STOP: begin
            if (nz_s[i]) begin
              state_d[i] = ST_DRIVE;
              dir_d[i]   = sgn_s[i];
              duty_d[i]  = RAMP_ON ? DUTY_ZERO : mag_s[i];
            end else begin
              state_d[i] = ST_STOP;
            end
          end
          ST_DRIVE: begin
            if (!nz_s[i] || (sgn_s[i] != dir_q[i])) begin
              if (!RAMP_ON || (duty_q[i] == DUTY_ZERO)) begin
                state_d[i] = ST_BRAKE;
                brk_d[i]   = DT_ZERO;
              end else begin
                duty_d[i] = ramp_to(duty_q[i], DUTY_ZERO);
              end
            end else begin
              duty_d[i] = ramp_to(duty_q[i], mag_s[i]);
            end
          end
          ST_BRAKE: begin
            if (brk_q[i] == DT_LAST) begin
              brk_d[i] = DT_ZERO;
              if (nz_s[i]) begin
                state_d[i] = ST_DRIVE;
                dir_d[i]   = sgn_s[i];
                duty_d[i]  = RAMP_ON ? DUTY_ZERO : mag_s[i];
              end else begin
                state_d[i] = ST_STOP;
              end
            end else begin
              brk_d[i] = brk_q[i] + 1'b1;
            end
          end
          default: begin
            state_d[i] = ST_STOP;
          end
        endcase
      end else begin
        state_d[i] = state_q[i];
      end
    end
  end

  // Outputs are derived from next-state so the registered pins line up with cnt_q.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i]  = (state_d[i] == ST_DRIVE) && (cnt_d < duty_d[i]);
      ina_d[i]  = (state_d[i] == ST_DRIVE) && !dir_d[i];
      inb_d[i]  = (state_d[i] == ST_DRIVE) && dir_d[i];
      busy_d[i] = (state_d[i] != ST_STOP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_STOP;
        dir_q[i]   <= 1'b0;
        duty_q[i]  <= DUTY_ZERO;
        brk_q[i]   <= DT_ZERO;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        dir_q[i]   <= dir_d[i];
        duty_q[i]  <= duty_d[i];
        brk_q[i]   <= brk_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= {PS_W{1'b0}};
      cnt_q       <= {PWM_BITS{1'b0}};
      cmd_ready_q <= 1'b0;
      pwm_q       <= {NUM_CH{1'b0}};
      ina_q       <= {NUM_CH{1'b0}};
      inb_q       <= {NUM_CH{1'b0}};
      busy_q      <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) tgt_q[i] <= SPD_ZERO;
    end else begin
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      pwm_q       <= pwm_d;
      ina_q       <= ina_d;
      inb_q       <= inb_d;
      busy_q      <= busy_d;
      for (int i = 0; i < NUM_CH; i++) tgt_q[i] <= tgt_d[i];
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign pwm       = pwm_q;
  assign ina       = ina_q;
  assign inb       = inb_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_hbridge_pwm_ctrl.sv
// Bench for hbridge_pwm_ctrl: directed scenarios plus random commands, checked every cycle
// against a period-level behavioural model of the bridges.
`timescale 1ns/1ps
module tb_hbridge_pwm_ctrl;
  localparam int NCH = 2;
  localparam int PB  = 4;
  localparam int PS  = 1;
  localparam int DT  = 2;
  localparam int PER = 1 << PB;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [0:0]        cmd_ch = 1'b0;
  logic signed [4:0] cmd_speed = 5'sd0;
  logic [1:0]        pwm, ina, inb, busy;

  always #5 clk = ~clk;

  hbridge_pwm_ctrl #(.NUM_CH(NCH), .PWM_BITS(PB), .PRESCALE(PS), .DEADTIME(DT), .RAMP_STEP(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_speed(cmd_speed), .pwm(pwm), .ina(ina), .inb(inb), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  // Model: mode 0 = stopped, 1 = driving, 2 = braking; m_brk counts boundaries spent braking.
  int m_tgt [NCH];
  int m_mode [NCH];
  int m_rev [NCH];
  int m_duty [NCH];
  int m_brk [NCH];
  int m_cnt = 0;
  int m_pre = 0;
  int m_ready = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clock(input bit r, input bit e, input bit v, input int c, input int s);
    bit bnd;
    if (r) begin
      for (int i = 0; i < NCH; i++) begin
        m_tgt[i] = 0; m_mode[i] = 0; m_rev[i] = 0; m_duty[i] = 0; m_brk[i] = 0;
      end
      m_cnt = 0; m_pre = 0; m_ready = 0;
      return;
    end
    bnd = (m_pre == PS - 1) && (m_cnt == PER - 1);
    for (int i = 0; i < NCH; i++) begin
      int t;
      t = m_tgt[i];
      if (!e) begin
        m_mode[i] = 2; m_brk[i] = 0;
      end else if (bnd) begin
        if (m_mode[i] == 0) begin
          if (t != 0) begin m_mode[i] = 1; m_rev[i] = (t < 0); m_duty[i] = (t < 0) ? -t : t; end
        end else if (m_mode[i] == 1) begin
          if (t == 0 || ((t < 0) != (m_rev[i] != 0))) begin m_mode[i] = 2; m_brk[i] = 0; end
          else m_duty[i] = (t < 0) ? -t : t;
        end else begin
          m_brk[i]++;
          if (m_brk[i] == DT) begin
            if (t != 0) begin m_mode[i] = 1; m_rev[i] = (t < 0); m_duty[i] = (t < 0) ? -t : t; end
            else m_mode[i] = 0;
          end
        end
      end
    end
    if (v && m_ready != 0 && c < NCH) m_tgt[c] = (s == -PER) ? -(PER - 1) : s;
    if (m_pre == PS - 1) begin m_pre = 0; m_cnt = (m_cnt + 1) % PER; end
    else m_pre++;
    m_ready = 1;
  endtask

  task automatic step();
    bit r = rst;
    bit e = enable;
    bit v = cmd_valid;
    int c = int'(cmd_ch);
    int s = int'(cmd_speed);
    @(posedge clk);
    model_clock(r, e, v, c, s);
    #1;
    check("cmd_ready", int'(cmd_ready), m_ready);
    for (int i = 0; i < NCH; i++) begin
      int drv;
      drv = (m_mode[i] == 1) ? 1 : 0;
      check($sformatf("pwm%0d", i), int'(pwm[i]), (drv == 1 && m_cnt < m_duty[i]) ? 1 : 0);
      check($sformatf("ina%0d", i), int'(ina[i]), (drv == 1 && m_rev[i] == 0) ? 1 : 0);
      check($sformatf("inb%0d", i), int'(inb[i]), (drv == 1 && m_rev[i] != 0) ? 1 : 0);
      check($sformatf("busy%0d", i), int'(busy[i]), (m_mode[i] != 0) ? 1 : 0);
      if (ina[i] && inb[i]) check("ina_inb_exclusive", 1, 0);
    end
  endtask

  task automatic send(input int ch, input int spd);
    cmd_ch = 1'(ch);
    cmd_speed = 5'(spd);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    int hi;
    // Reset held three cycles
    rst = 1'b1;
    repeat (3) step();
    check("rst_ready", int'(cmd_ready), 0);
    check("rst_pwm", int'(pwm), 0);
    check("rst_dir", int'(ina | inb), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    enable = 1'b1;
    step();
    check("ready_after_rst", int'(cmd_ready), 1);

    // Forward +4 on channel 0
    send(0, 4);
    n = 0;
    while (ina[0] !== 1'b1 && n < 40) begin step(); n++; end
    check("fwd_ina0", int'(ina[0]), 1);
    check("fwd_inb0", int'(inb[0]), 0);
    check("fwd_busy0", int'(busy[0]), 1);
    hi = int'(pwm[0]);
    repeat (PER - 1) begin step(); hi += int'(pwm[0]); end
    check("fwd_duty4", hi, 4);
    check("fwd_ch1_idle", int'({pwm[1], ina[1], inb[1], busy[1]}), 0);

    // Reversal to -8, command lands on a boundary cycle
    send(0, -8);
    n = 0;
    while (ina[0] !== 1'b0 && n < 40) begin step(); n++; end
    n = 0;
    while (pwm[0] == 1'b0 && ina[0] == 1'b0 && inb[0] == 1'b0 && n < 100) begin step(); n++; end
    check("rev_gap", n, 32);
    check("rev_inb0", int'(inb[0]), 1);
    hi = int'(pwm[0]);
    repeat (PER - 1) begin step(); hi += int'(pwm[0]); end
    check("rev_duty8", hi, 8);

    // Saturation of -16 on channel 1, then stop through brake
    send(1, -16);
    n = 0;
    while (inb[1] !== 1'b1 && n < 40) begin step(); n++; end
    check("sat_inb1", int'(inb[1]), 1);
    hi = int'(pwm[1]);
    repeat (PER - 1) begin step(); hi += int'(pwm[1]); end
    check("sat_duty15", hi, 15);
    send(1, 0);
    n = 0;
    while (inb[1] !== 1'b0 && n < 40) begin step(); n++; end
    n = 0;
    while (busy[1] == 1'b1 && inb[1] == 1'b0 && n < 100) begin step(); n++; end
    check("stop_brake_len", n, 32);
    check("stop_busy1", int'(busy[1]), 0);

    // Enable drop mid-period, reassert at period start
    n = 0;
    while (m_cnt != 6 && n < 40) begin step(); n++; end
    enable = 1'b0;
    step();
    check("en_low_pwm", int'(pwm), 0);
    check("en_low_dir", int'(ina | inb), 0);
    check("en_low_busy", int'(busy), 3);
    n = 0;
    while (m_cnt != 0 && n < 40) begin step(); n++; end
    enable = 1'b1;
    n = 0;
    while (pwm[0] == 1'b0 && n < 100) begin step(); n++; end
    check("en_resume", n, 32);
    check("en_resume_inb0", int'(inb[0]), 1);

    // Random commands, occasional enable drops and resets
    for (int k = 0; k < 3000; k++) begin
      cmd_valid = ($urandom_range(0, 99) < 8);
      cmd_ch    = 1'($urandom_range(0, 1));
      cmd_speed = 5'($urandom_range(0, 31));
      enable    = ($urandom_range(0, 199) != 0);
      rst       = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    enable = 1'b1;
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hbridge_pwm_ctrl.md
# hbridge_pwm_ctrl

Parametrised multi-channel H-bridge motor controller, the successor to the fixed two-channel motor-driver test FSM. It accepts signed per-channel speed commands over a valid/ready port and generates PWM plus INA/INB direction pins for each bridge. Every direction reversal passes through a timed brake (dead-time) state. Outputs connect directly to GPIO at top level.

## Interface
- `NUM_CH`, 2: number of motor channels.
- `PWM_BITS`, 8: PWM resolution; period = 2^PWM_BITS ticks.
- `PRESCALE`, 4: `clk` cycles per PWM tick (≥1); PWM freq = f_clk/(PRESCALE·2^PWM_BITS).
- `DEADTIME`, 16: PWM periods spent in BRAKE before re-driving (≥1).
- `RAMP_STEP`, 1: max duty change per PWM period (used only with ramp option).
- `CW` (localparam): max(1, $clog2(NUM_CH)).

- `clk` in 1: system clock (CLOCK_50 at top).
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: global drive enable; low forces all bridges to brake.
- `cmd_valid` in 1: command strobe.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_ch` in CW: target channel; values ≥ NUM_CH are accepted and discarded.
- `cmd_speed` in PWM_BITS+1: signed speed; sign = direction, magnitude = duty.
- `pwm` out NUM_CH: per-channel PWM.
- `ina` out NUM_CH: bridge input A (1 = forward).
- `inb` out NUM_CH: bridge input B (1 = reverse).
- `busy` out NUM_CH: channel state ≠ STOP.

## Operation
- Shared free-running tick prescaler and PWM counter `cnt` (PWM_BITS). A period boundary is a tick with `cnt` = 2^PWM_BITS−1.
- Command accept writes `target[cmd_ch]` = saturated `cmd_speed`. −2^PWM_BITS is clamped to magnitude 2^PWM_BITS−1. `cmd_ready` = !rst (always 1 outside reset).
- Per-channel FSM (STOP, DRIVE, BRAKE) evaluates only at period boundaries:
  - STOP: target ≠ 0 → DRIVE with dir = sign(target) and duty loaded; otherwise stay.
  - DRIVE: target 0 or sign ≠ dir → BRAKE, with the brake counter cleared; otherwise duty updates to |target|.
  - BRAKE: counts boundaries; after DEADTIME boundaries → DRIVE (new dir) if target ≠ 0, else STOP.
- Outputs:
  - DRIVE: ina = !dir_rev, inb = dir_rev, pwm = (cnt < duty).
  - STOP and BRAKE: ina = inb = pwm = 0.
  - ina and inb are never both 1.
- `enable` low: on the next clock every channel enters BRAKE, its brake counter is held at 0 and all outputs are 0. Targets are retained. When `enable` rises, the normal BRAKE countdown resumes.
- Duty 0 in DRIVE gives pwm constantly 0 with direction pins asserted. Duty 2^PWM_BITS−1 gives pwm low for 1 tick per period.
- A new command to a channel overwrites the previous target. When a command coincides with a boundary, the boundary uses the old target.

## Timing
- Reset values: pwm = ina = inb = busy = 0, cmd_ready = 0, cnt = 0, prescaler = 0, all targets 0, all states STOP.
- All outputs are registered.
- A command accepted in cycle k is visible in `target` at k+1 and takes effect at the first period boundary after k+1. Outputs change one clock after that boundary.
- Reversal latency: DEADTIME full periods of brake between the last forward pulse and the first reverse pulse.
- `rst` mid-operation returns everything to reset values on the next clock, with no brake phase.

## Configuration
- `HBRIDGE_RAMP_EN` defined:
  - Applied duty moves toward |target| by at most RAMP_STEP per boundary.
  - Entry from STOP/BRAKE into DRIVE starts at duty 0.
  - DRIVE → BRAKE on a sign change or zero target happens only once applied duty reaches 0.
- Undefined: duty jumps to |target| at the boundary and RAMP_STEP is unused.

## Test plan
All scenarios use NUM_CH=2, PWM_BITS=4, PRESCALE=1, DEADTIME=2, so one period = 16 clocks.
- Reset: hold rst 3 cycles → all outputs 0 and cmd_ready 0; one cycle after rst falls, cmd_ready = 1.
- Forward drive: ch0 speed +4 → after the next boundary ina0=1, inb0=0, pwm0 high 4 of every 16 clocks, busy0=1; ch1 outputs stay 0.
- Reversal: ch0 at +4, then command −8 → pwm0=ina0=inb0=0 for exactly 32 clocks, then inb0=1 and pwm0 high 8/16.
- Saturation: ch1 speed −16 → inb1=1, pwm1 high 15 of 16 clocks; ch1 speed 0 → BRAKE for 2 periods, then STOP with busy1=0.
- Enable drop: ch0 driving +4, deassert enable mid-period → all outputs 0 on the next clock; reassert → pwm resumes after 2 full periods.
- Ramp (`HBRIDGE_RAMP_EN`, RAMP_STEP=1): ch0 +3 from STOP → duty 0, 1, 2, 3 over successive periods; then command 0 → duty 2, 1, 0, then BRAKE.
